clock_core: RTL

CLOCK_CORE -- requirements
Module: clock_core

---
 rtl/clock_core.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/clock_core.sv
// clock_core: time-of-week counter with time-set and alarm-set modes.
// Holds seconds, minutes, hours and day of week, plus an alarm setting
// (minutes, hours, day) for a downstream comparator. All counting is gated
// by a one-cycle 1 Hz Pulse enable. Every output comes straight from a
// register or is a constant.
//
// Build option: define CLOCK_DAY_COUNTER_EN to include the day-of-week
// counters (tday, aday). Without it both read 0, Dayadv is ignored and an
// hours wrap carries nowhere.
module clock_core (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Pulse,
  input  logic       Timeset,
  input  logic       Alarmset,
  input  logic       Minadv,
  input  logic       Hrsadv,
  input  logic       Dayadv,
  output logic [6:0] tsec,
  output logic [6:0] tmin,
  output logic [6:0] thrs,
  output logic [6:0] tday,
  output logic [6:0] amin,
  output logic [6:0] ahrs,
  output logic [6:0] aday,
  output logic [1:0] mode
);

  // Mode encoding doubles as the mode output value.
  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_SET_TIME  = 2'd1;
  localparam logic [1:0] ST_SET_ALARM = 2'd2;

  // Terminal values for each field at its natural width.
  localparam logic [5:0] SEC_MAX = 6'd59;
  localparam logic [5:0] MIN_MAX = 6'd59;
  localparam logic [4:0] HRS_MAX = 5'd23;

  // Wrap-around increments; each compares against the terminal value so
  // an out-of-range value can never be produced.
  function automatic logic [5:0] inc6(input logic [5:0] v, input logic [5:0] term);
    return (v == term) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc5(input logic [4:0] v, input logic [4:0] term);
    return (v == term) ? 5'd0 : v + 5'd1;
  endfunction

  logic [1:0] state_reg;
  logic [1:0] state_next;

  logic [5:0] sec_reg;
  logic [5:0] sec_next;
  logic [5:0] min_reg;
  logic [5:0] min_next;
  logic [4:0] hrs_reg;
  logic [4:0] hrs_next;

  logic [5:0] amin_reg;
  logic [5:0] amin_next;
  logic [4:0] ahrs_reg;
  logic [4:0] ahrs_next;

  logic in_set_time;
  logic in_set_alarm;
  logic run_tick;
  logic set_tick;
  logic alarm_tick;
  logic sec_wrap;
  logic min_wrap;
  logic hrs_wrap;
  logic min_carry;
  logic hrs_carry;

  // Mode selection: Timeset wins over Alarmset; evaluated every cycle.
  always_comb begin
    if (Timeset) begin
      state_next = ST_SET_TIME;
    end else if (Alarmset) begin
      state_next = ST_SET_ALARM;
    end else begin
      state_next = ST_RUN;
    end
  end

  // Tick qualifiers and carry chain, all decoded from the pre-edge mode so
  // a Pulse on a mode-change edge is applied exactly once, by the old mode.
  always_comb begin
    in_set_time  = (state_reg == ST_SET_TIME);
    in_set_alarm = (state_reg == ST_SET_ALARM);
    run_tick     = Pulse & ~in_set_time;
    set_tick     = Pulse & in_set_time;
    alarm_tick   = Pulse & in_set_alarm;
    sec_wrap     = (sec_reg == SEC_MAX);
    min_wrap     = (min_reg == MIN_MAX);
    hrs_wrap     = (hrs_reg == HRS_MAX);
    min_carry    = run_tick & sec_wrap;
    hrs_carry    = min_carry & min_wrap;
  end

  // Seconds: held at zero while setting the time, otherwise counts on Pulse.
  always_comb begin
    sec_next = sec_reg;
    if (in_set_time) begin
      sec_next = 6'd0;
    end else if (run_tick) begin
      sec_next = inc6(sec_reg, SEC_MAX);
    end
  end

  // Minutes and hours: advanced either by a manual set (no carries) or by
  // the running carry chain; the two sources are mutually exclusive.
  always_comb begin
    min_next = min_reg;
    hrs_next = hrs_reg;
    if ((set_tick & Minadv) | min_carry) begin
      min_next = inc6(min_reg, MIN_MAX);
    end
    if ((set_tick & Hrsadv) | hrs_carry) begin
      hrs_next = inc5(hrs_reg, HRS_MAX);
    end
  end

  // Alarm minutes and hours: only manual advances in alarm-set mode.
  always_comb begin
    amin_next = amin_reg;
    ahrs_next = ahrs_reg;
    if (alarm_tick & Minadv) begin
      amin_next = inc6(amin_reg, MIN_MAX);
    end
    if (alarm_tick & Hrsadv) begin
      ahrs_next = inc5(ahrs_reg, HRS_MAX);
    end
  end

  // Mode register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  // Time-of-day registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sec_reg <= 6'd0;
      min_reg <= 6'd0;
      hrs_reg <= 5'd0;
    end else begin
      sec_reg <= sec_next;
      min_reg <= min_next;
      hrs_reg <= hrs_next;
    end
  end

  // Alarm setting registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      amin_reg <= 6'd0;
      ahrs_reg <= 5'd0;
    end else begin
      amin_reg <= amin_next;
      ahrs_reg <= ahrs_next;
    end
  end

`ifdef CLOCK_DAY_COUNTER_EN
  localparam logic [2:0] DAY_MAX = 3'd6;

  function automatic logic [2:0] inc3(input logic [2:0] v, input logic [2:0] term);
    return (v == term) ? 3'd0 : v + 3'd1;
  endfunction

  logic [2:0] day_reg;
  logic [2:0] day_next;
  logic [2:0] aday_reg;
  logic [2:0] aday_next;
  logic       day_carry;

  // Day counters: the time day takes the full carry chain or a manual set,
  // the alarm day only a manual set in alarm-set mode.
  always_comb begin
    day_carry = hrs_carry & hrs_wrap;
    day_next  = day_reg;
    aday_next = aday_reg;
    if ((set_tick & Dayadv) | day_carry) begin
      day_next = inc3(day_reg, DAY_MAX);
    end
    if (alarm_tick & Dayadv) begin
      aday_next = inc3(aday_reg, DAY_MAX);
    end
  end

  // Day registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      day_reg  <= 3'd0;
      aday_reg <= 3'd0;
    end else begin
      day_reg  <= day_next;
      aday_reg <= aday_next;
    end
  end

  assign tday = {4'd0, day_reg};
  assign aday = {4'd0, aday_reg};
`else
  // Without the day counters the hours wrap and Dayadv go nowhere.
  logic unused_day_inputs;
  assign unused_day_inputs = Dayadv | hrs_wrap;

  assign tday = 7'd0;
  assign aday = 7'd0;
`endif

  assign tsec = {1'b0, sec_reg};
  assign tmin = {1'b0, min_reg};
  assign thrs = {2'b0, hrs_reg};
  assign amin = {1'b0, amin_reg};
  assign ahrs = {2'b0, ahrs_reg};
  assign mode = state_reg;

endmodule
